// File: rtl/axi_lite_read_arbiter_pkg.sv
// Shared definitions for the AXI-lite read arbiter.
//   MST_IFU / MST_LSU : 1-bit owner ids stored in the order FIFO and used as the grant value
//   arb_state_e       : ARB (free arbitration) / LOCK (grant frozen while AR is stalled)
//   RESP_*            : AXI response codes; rresp is passed through unmodified
//   other_mst()       : the master that did not win, used by the round-robin pointer
package axi_lite_read_arbiter_pkg;

    localparam logic MST_IFU = 1'b0;
    localparam logic MST_LSU = 1'b1;

    typedef enum logic {
        ARB_ST_ARB  = 1'b0,
        ARB_ST_LOCK = 1'b1
    } arb_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    function automatic logic other_mst(input logic mst);
        return ~mst;
    endfunction

endpackage

// File: rtl/axi_lite_read_arbiter_order_fifo.sv
// arb_order_fifo: 1-bit wide, DEPTH deep FIFO of AR owner ids.
//   clk, rst      : clock, asynchronous active-high reset (FIFO empties)
//   push, push_id : write push_id at the tail (caller never pushes when full)
//   pop           : drop the head entry (caller never pops when empty)
//   full, empty   : occupancy flags from the registered count
//   head          : owner id of the oldest entry, combinational
// DEPTH must be a power of two so the pointers wrap naturally.
module arb_order_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic push_id,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0] slot_reg;
    logic [DEPTH-1:0] slot_wr_en;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot_wr
            assign slot_wr_en[gi] = push && (wr_ptr_reg == PTR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_reg   <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (slot_wr_en[i]) begin
                    slot_reg[i] <= push_id;
                end
            end
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            // Simultaneous push and pop leaves the count unchanged.
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);
    assign head  = slot_reg[rd_ptr_reg];

endmodule

// File: rtl/axi_lite_read_arbiter.sv
// axi_lite_read_arbiter: shares one AXI-lite read port (AR + R) between the
// instruction fetch unit (m0) and the load/store unit (m1).
//   clk, rst           : core clock, asynchronous active-high reset
//   m0_* / m1_*        : ifu / lsu AR and R channels (slave side of the arbiter)
//   s_*                : AR and R channels towards the memory / crossbar slave
// AXI-lite carries no IDs, so an order FIFO records the owner of every accepted
// AR and steers the in-order R beats back to it. AR and R paths are combinational.
// Build option ARB_RR_EN: round-robin between the masters; when undefined the
// lsu (m1) has fixed priority over the ifu (m0).
module axi_lite_read_arbiter
    import axi_lite_read_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 32,
    parameter int OST_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_arvalid,
    output logic              m0_arready,
    input  logic [ADDR_W-1:0] m0_araddr,
    output logic              m0_rvalid,
    input  logic              m0_rready,
    output logic [1:0]        m0_rresp,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_arvalid,
    output logic              m1_arready,
    input  logic [ADDR_W-1:0] m1_araddr,
    output logic              m1_rvalid,
    input  logic              m1_rready,
    output logic [1:0]        m1_rresp,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              s_arvalid,
    input  logic              s_arready,
    output logic [ADDR_W-1:0] s_araddr,
    input  logic              s_rvalid,
    output logic              s_rready,
    input  logic [1:0]        s_rresp,
    input  logic [DATA_W-1:0] s_rdata
);

    arb_state_e        state_reg, state_next;
    logic              grant_reg, grant_next;
    logic              arb_pick;
    logic              grant;
    logic              sel_arvalid;
    logic [ADDR_W-1:0] sel_araddr;
    logic              ar_present;
    logic              ar_push;
    logic              r_accept;
    logic              r_pop;
    logic              fifo_full, fifo_empty, fifo_head;

`ifdef ARB_RR_EN
    // rr_reg names the master that wins when both request.
    logic rr_reg, rr_next;

    always_comb begin
        rr_next = rr_reg;
        if (ar_push) begin
            rr_next = other_mst(grant);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_reg <= MST_IFU;
        end else begin
            rr_reg <= rr_next;
        end
    end

    always_comb begin
        arb_pick = grant_reg;
        if (m0_arvalid && m1_arvalid) begin
            arb_pick = rr_reg;
        end else if (m1_arvalid) begin
            arb_pick = MST_LSU;
        end else if (m0_arvalid) begin
            arb_pick = MST_IFU;
        end
    end
`else
    always_comb begin
        arb_pick = grant_reg;
        if (m1_arvalid) begin
            arb_pick = MST_LSU;
        end else if (m0_arvalid) begin
            arb_pick = MST_IFU;
        end
    end
`endif

    // Once an AR has been presented and stalled, the grant must not move,
    // otherwise s_arvalid/s_araddr would change before the handshake.
    assign grant = (state_reg == ARB_ST_LOCK) ? grant_reg : arb_pick;

    assign sel_arvalid = (grant == MST_LSU) ? m1_arvalid : m0_arvalid;
    assign sel_araddr  = (grant == MST_LSU) ? m1_araddr  : m0_araddr;

    // A full FIFO blocks AR outright, even if a pop happens this cycle.
    assign ar_present = sel_arvalid && !fifo_full;
    assign ar_push    = ar_present && s_arready;

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        case (state_reg)
            ARB_ST_ARB: begin
                grant_next = arb_pick;
                if (ar_present && !s_arready) begin
                    state_next = ARB_ST_LOCK;
                end
            end
            ARB_ST_LOCK: begin
                if (ar_push) begin
                    state_next = ARB_ST_ARB;
                end
            end
            default: begin
                state_next = ARB_ST_ARB;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ARB_ST_ARB;
            grant_reg <= MST_LSU;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
        end
    end

    // R steering: the FIFO head owns the current beat. With an empty FIFO
    // s_rready stays low, so a stray beat stalls instead of being misrouted.
    assign r_accept = !fifo_empty && ((fifo_head == MST_LSU) ? m1_rready : m0_rready);
    assign r_pop    = s_rvalid && r_accept;

    arb_order_fifo #(
        .DEPTH (OST_DEPTH)
    ) u_order_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (ar_push),
        .push_id (grant),
        .pop     (r_pop),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (fifo_head)
    );

    // Handshake outputs are forced low for as long as rst is held.
    assign s_arvalid  = ar_present && !rst;
    assign s_araddr   = sel_araddr;
    assign m0_arready = !rst && !fifo_full && s_arready && (grant == MST_IFU);
    assign m1_arready = !rst && !fifo_full && s_arready && (grant == MST_LSU);

    assign s_rready  = r_accept && !rst;
    assign m0_rvalid = !rst && !fifo_empty && s_rvalid && (fifo_head == MST_IFU);
    assign m1_rvalid = !rst && !fifo_empty && s_rvalid && (fifo_head == MST_LSU);

    assign m0_rdata = s_rdata;
    assign m1_rdata = s_rdata;
    assign m0_rresp = s_rresp;
    assign m1_rresp = s_rresp;

endmodule

// File: tb/tb_axi_lite_read_arbiter.sv
// Testbench for axi_lite_read_arbiter: directed scenarios followed by random
// traffic, every cycle checked against a transaction-level model (queue of
// outstanding owners, the master whose AR is currently presented, and the
// arbitration policy). Honours ARB_RR_EN the same way as the design.
module tb_axi_lite_read_arbiter;
    import axi_lite_read_arbiter_pkg::*;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              m0_arvalid, m0_arready, m0_rvalid, m0_rready;
    logic [ADDR_W-1:0] m0_araddr;
    logic [1:0]        m0_rresp;
    logic [DATA_W-1:0] m0_rdata;
    logic              m1_arvalid, m1_arready, m1_rvalid, m1_rready;
    logic [ADDR_W-1:0] m1_araddr;
    logic [1:0]        m1_rresp;
    logic [DATA_W-1:0] m1_rdata;
    logic              s_arvalid, s_arready, s_rvalid, s_rready;
    logic [ADDR_W-1:0] s_araddr;
    logic [1:0]        s_rresp;
    logic [DATA_W-1:0] s_rdata;

    always #5 clk = ~clk;

    axi_lite_read_arbiter #(
        .ADDR_W (ADDR_W), .DATA_W (DATA_W), .OST_DEPTH (DEPTH)
    ) dut (
        .clk (clk), .rst (rst),
        .m0_arvalid (m0_arvalid), .m0_arready (m0_arready), .m0_araddr (m0_araddr),
        .m0_rvalid (m0_rvalid), .m0_rready (m0_rready), .m0_rresp (m0_rresp), .m0_rdata (m0_rdata),
        .m1_arvalid (m1_arvalid), .m1_arready (m1_arready), .m1_araddr (m1_araddr),
        .m1_rvalid (m1_rvalid), .m1_rready (m1_rready), .m1_rresp (m1_rresp), .m1_rdata (m1_rdata),
        .s_arvalid (s_arvalid), .s_arready (s_arready), .s_araddr (s_araddr),
        .s_rvalid (s_rvalid), .s_rready (s_rready), .s_rresp (s_rresp), .s_rdata (s_rdata)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    bit own_q[$];        // owners of accepted, unanswered ARs, oldest first
    int pend   = -1;     // master whose AR was presented and not yet accepted
    bit rr_pref = 1'b0;  // preferred master on a double request (round-robin)
    bit last_g  = 1'b1;  // grant shown when nobody requests
    bit e_g, e_arv, e_ar_hs, e_r_hs;

    task automatic sample();
        bit full, empty, g, h;
        logic [5:0] ev, gv;
        #3;
        full  = (own_q.size() == DEPTH);
        empty = (own_q.size() == 0);
        if (pend >= 0)                     g = pend[0];
        else if (m0_arvalid && m1_arvalid) g = RR ? rr_pref : 1'b1;
        else if (m1_arvalid)               g = 1'b1;
        else if (m0_arvalid)               g = 1'b0;
        else                               g = last_g;
        h = empty ? 1'b0 : own_q[0];
        ev = '0;
        if (!rst) begin
            ev[5] = (g ? m1_arvalid : m0_arvalid) && !full;
            ev[4] = !g && s_arready && !full;
            ev[3] = g && s_arready && !full;
            ev[2] = !empty && s_rvalid && !h;
            ev[1] = !empty && s_rvalid && h;
            ev[0] = !empty && (h ? m1_rready : m0_rready);
        end
        e_g     = g;
        e_arv   = ev[5];
        e_ar_hs = ev[5] && s_arready;
        e_r_hs  = ev[0] && s_rvalid;
        gv = {s_arvalid, m0_arready, m1_arready, m0_rvalid, m1_rvalid, s_rready};
        chk("handshakes", 64'(gv), 64'(ev));
        if (ev[5]) chk("s_araddr", 64'(s_araddr), 64'(g ? m1_araddr : m0_araddr));
        if (s_rvalid) begin
            chk("rdata_bcast", 64'({m0_rdata, m1_rdata}), 64'({s_rdata, s_rdata}));
            chk("rresp_bcast", 64'({m0_rresp, m1_rresp}), 64'({s_rresp, s_rresp}));
        end
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) begin
            own_q.delete();
            pend = -1; rr_pref = 1'b0; last_g = 1'b1;
        end else begin
            if (e_r_hs) void'(own_q.pop_front());
            if (e_ar_hs) begin
                own_q.push_back(e_g);
                pend = -1;
                rr_pref = !e_g;
            end else if (e_arv) begin
                pend = int'(e_g);
            end
            last_g = e_g;
        end
        #1;
    endtask

    task automatic cyc();
        sample();
        advance();
    endtask

    task automatic drain();
        m0_arvalid = 0; m1_arvalid = 0;
        s_rvalid = 1; m0_rready = 1; m1_rready = 1;
        for (int i = 0; i < 12 && own_q.size() != 0; i++) cyc();
        s_rvalid = 0;
    endtask

    task automatic rand_drive();
        bit hold0, hold1, hold_r;
        hold0  = m0_arvalid && !(e_ar_hs && !e_g);
        hold1  = m1_arvalid && !(e_ar_hs && e_g);
        hold_r = s_rvalid && !e_r_hs;
        if (!hold0) begin
            m0_arvalid = ($urandom_range(0, 2) != 0);
            m0_araddr  = {$urandom, $urandom};
        end
        if (!hold1) begin
            m1_arvalid = ($urandom_range(0, 2) != 0);
            m1_araddr  = {$urandom, $urandom};
        end
        if (!hold_r) begin
            s_rvalid = ($urandom_range(0, 1) != 0);
            s_rdata  = $urandom;
            s_rresp  = 2'($urandom_range(0, 3));
        end
        s_arready = ($urandom_range(0, 3) != 0);
        m0_rready = ($urandom_range(0, 3) != 0);
        m1_rready = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        int acc;
        rst = 0;
        m0_arvalid = 0; m0_araddr = '0; m0_rready = 0;
        m1_arvalid = 0; m1_araddr = '0; m1_rready = 0;
        s_arready = 0; s_rvalid = 0; s_rresp = RESP_OKAY; s_rdata = '0;
        #1 rst = 1;
        // Reset with every input pushing: all handshake outputs stay low.
        m0_arvalid = 1; m1_arvalid = 1; s_arready = 1; s_rvalid = 1; m0_rready = 1; m1_rready = 1;
        sample();
        chk("rst_outputs", 64'({s_arvalid, m0_arready, m1_arready, s_rready}), 64'(0));
        advance();
        cyc();
        m0_arvalid = 0; m1_arvalid = 0; s_rvalid = 0; m0_rready = 0; m1_rready = 0;
        rst = 0;
        cyc();

        // 1: m0 alone fills the FIFO; the 5th AR waits until the cycle after a pop.
        s_arready = 1; m0_arvalid = 1;
        for (int i = 0; i < 5; i++) begin
            m0_araddr = 64'(i * 4);
            sample();
            chk($sformatf("t1_ar%0d_ready", i), 64'(m0_arready), 64'(i < 4));
            advance();
        end
        s_rvalid = 1; s_rdata = 32'hA1; m0_rready = 1;
        sample();
        chk("t1_no_ar_on_pop_cycle", 64'(m0_arready), 64'(0));
        advance();
        s_rvalid = 0;
        sample();
        chk("t1_ar_after_pop", 64'({s_arvalid, m0_arready}), 64'(2'b11));
        advance();
        drain();

        // 2: simultaneous requests.
        m0_araddr = 64'h1000; m1_araddr = 64'h2000;
        m0_arvalid = 1; m1_arvalid = 1; s_arready = 1;
        s_rvalid = 1; m0_rready = 1; m1_rready = 1;
        for (int i = 0; i < 4; i++) begin
            sample();
            chk($sformatf("t2_addr%0d", i), 64'(s_araddr),
                (RR && (i % 2 == 0)) ? 64'h1000 : 64'h2000);
            advance();
        end
        drain();

        // 3: stalled AR locks the grant to m0 while m1 arrives.
        s_arready = 0; m0_arvalid = 1; m0_araddr = 64'h3000; m1_araddr = 64'h4000;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) m1_arvalid = 1;
            if (i == 3) s_arready = 1;
            sample();
            chk($sformatf("t3_lock%0d", i), 64'({s_araddr[31:0], m1_arready}), 64'({32'h3000, 1'b0}));
            advance();
        end
        m0_arvalid = 0;
        sample();
        chk("t3_m1_after", 64'({s_araddr[31:0], m1_arready}), 64'({32'h4000, 1'b1}));
        advance();
        drain();

        // 4: order m0, m1, m0; m1 holds off its beat for 2 cycles.
        s_arready = 1;
        m0_arvalid = 1; m0_araddr = 64'h10; cyc();
        m0_arvalid = 0; m1_arvalid = 1; m1_araddr = 64'h20; cyc();
        m1_arvalid = 0; m0_arvalid = 1; m0_araddr = 64'h30; cyc();
        m0_arvalid = 0;
        s_rvalid = 1; s_rdata = 32'hAAAA; m0_rready = 1; m1_rready = 0;
        sample();
        chk("t4_A_to_m0", 64'({m0_rvalid, m1_rvalid, m0_rdata}), 64'({2'b10, 32'hAAAA}));
        advance();
        s_rdata = 32'hBBBB;
        for (int i = 0; i < 2; i++) begin
            sample();
            chk($sformatf("t4_B_stall%0d", i), 64'({m0_rvalid, m1_rvalid, s_rready}), 64'(3'b010));
            advance();
        end
        m1_rready = 1;
        sample();
        chk("t4_B_taken", 64'({m1_rvalid, s_rready}), 64'(2'b11));
        advance();
        s_rdata = 32'hCCCC;
        sample();
        chk("t4_C_to_m0", 64'({m0_rvalid, m1_rvalid, m0_rdata}), 64'({2'b10, 32'hCCCC}));
        advance();
        s_rvalid = 0;

        // 5: push and pop together at count 2, carrying SLVERR.
        m0_arvalid = 1; cyc(); cyc();
        m0_arvalid = 0; m1_arvalid = 1; m1_araddr = 64'h50;
        s_rvalid = 1; s_rresp = RESP_SLVERR; s_rdata = 32'h5555; m0_rready = 1;
        sample();
        chk("t5_slverr", 64'({m0_rvalid, m0_rresp, m1_arready}), 64'({1'b1, RESP_SLVERR, 1'b1}));
        advance();
        m1_arvalid = 0; s_rvalid = 0; s_rresp = RESP_OKAY; m0_arvalid = 1;
        acc = 0;
        for (int i = 0; i < 3; i++) begin
            sample();
            acc += int'(m0_arready);
            advance();
        end
        chk("t5_count_stayed_2", 64'(acc), 64'(2));
        m0_arvalid = 0; s_rvalid = 1; m0_rready = 1;
        cyc();
        s_rvalid = 0;

        // 6: reset with 3 reads outstanding.
        rst = 1;
        m0_arvalid = 1; m1_arvalid = 1; s_arready = 1; s_rvalid = 1; m0_rready = 1; m1_rready = 1;
        sample();
        chk("t6_rst_outputs", 64'({s_arvalid, m0_arready, m1_arready, m0_rvalid, m1_rvalid, s_rready}), 64'(0));
        advance();
        cyc();
        rst = 0; m0_arvalid = 0; m1_arvalid = 0;
        sample();
        chk("t6_fifo_empty", 64'({s_rready, m0_rvalid, m1_rvalid}), 64'(0));
        advance();
        s_rvalid = 0; m0_arvalid = 1; m0_araddr = 64'h60;
        sample();
        chk("t6_arb_state", 64'({s_arvalid, m0_arready}), 64'(2'b11));
        advance();
        m0_arvalid = 0;
        drain();

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            rand_drive();
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
